d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop.sv | 23 ++
 tb/tb_d_flip_flop.sv | 125 ++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// Width-parameterizable positive-edge D flip-flop with synchronous active-high reset.
// Q is a pure flop output; nothing from D or RESET reaches it except through CLK.
module d_flip_flop #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] D,
  input  logic             CLK,
  input  logic             RESET,
  output logic [WIDTH-1:0] Q
);

  // NOTE: non-blocking assignment in an edge-only process; RESET is deliberately
  // absent from the sensitivity list so it takes effect only at a rising CLK edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q <= RESET_VALUE;
    end else begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: a 1-bit default instance and an 8-bit instance
// with reset value 8'hA5, driven by hand sequences and a vector table.
module tb_d_flip_flop;

  logic       clk;
  logic       rst1;
  logic       d1;
  logic       q1;
  logic       rst8;
  logic [7:0] d8;
  logic [7:0] q8;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       rst1;
    logic       d1;
    logic       exp1;
    logic       rst8;
    logic [7:0] d8;
    logic [7:0] exp8;
  } vec_t;

  vec_t vecs[$];

  d_flip_flop dut1 (
    .D     (d1),
    .CLK   (clk),
    .RESET (rst1),
    .Q     (q1)
  );

  d_flip_flop #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) dut8 (
    .D     (d8),
    .CLK   (clk),
    .RESET (rst8),
    .Q     (q8)
  );

  // Rising edges at t = 2, 6, 10, 14, ...
  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic       prev1;
    logic [7:0] prev8;
    checks = 0;
    errors = 0;

    // Hand sequence on absolute times.
    rst1 = 1'b0;
    d1   = 1'b0;
    rst8 = 1'b1;
    d8   = 8'h00;
    #3;  // t=3, after first rising edge
    check("first_edge_q1", {7'b0, q1}, 8'h00);
    check("first_edge_reset_q8", q8, 8'hA5);
    #1;  // t=4, falling edge
    d1 = 1'b1;
    #1;  // t=5
    check("d_change_on_falling_edge", {7'b0, q1}, 8'h00);
    #2;  // t=7, after t=6 edge
    check("load_one", {7'b0, q1}, 8'h01);
    d1 = 1'b0;                 // low pulse strictly between edges
    d8 = 8'hFF;
    #1;  // t=8
    rst1 = 1'b1;
    #1;  // t=9
    d1 = 1'b1;
    d8 = 8'h00;
    check("mid_cycle_pulse_and_reset_no_effect", {7'b0, q1}, 8'h01);
    check("q8_held_in_reset", q8, 8'hA5);
    #2;  // t=11, after t=10 edge
    check("reset_clears", {7'b0, q1}, 8'h00);
    #4;  // t=15, after t=14 edge
    check("reset_held", {7'b0, q1}, 8'h00);

    // Vector table: applied at a falling edge, checked just after the next rising edge.
    vecs.push_back('{"rst_d0",      1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hA5});
    vecs.push_back('{"rst_d1",      1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C});
    vecs.push_back('{"rst_d0_b",    1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF});
    vecs.push_back('{"rst_d1_b",    1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hA5});
    vecs.push_back('{"release_d1",  1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h5A});
    vecs.push_back('{"load_zero",   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{"load_one_b",  1'b0, 1'b1, 1'b1, 1'b1, 8'hC3, 8'hA5});
    vecs.push_back('{"rst_dom_d",   1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 8'h81});
    vecs.push_back('{"after_rst",   1'b0, 1'b0, 1'b0, 1'b0, 8'h7E, 8'h7E});

    prev1 = 1'b0;
    prev8 = 8'hA5;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst1 = vecs[i].rst1;
      d1   = vecs[i].d1;
      rst8 = vecs[i].rst8;
      d8   = vecs[i].d8;
      #1;
      check({vecs[i].name, "_hold_q1"}, {7'b0, q1}, {7'b0, prev1});
      check({vecs[i].name, "_hold_q8"}, q8, prev8);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_q1"}, {7'b0, q1}, {7'b0, vecs[i].exp1});
      check({vecs[i].name, "_q8"}, q8, vecs[i].exp8);
      prev1 = vecs[i].exp1;
      prev8 = vecs[i].exp8;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
